// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = !OP_ADD;

  // Width of one carry-chain slice; guarded so a bad STAGES still elaborates to the error.
  function automatic int slice_w(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational S-bit adder slice with carry-in, carry-out and MSB signed overflow.
module addsub_slice #(
  parameter int S = 4
) (
  input  logic [S-1:0] a_i,
  input  logic [S-1:0] b_i,
  input  logic         c_i,
  output logic [S-1:0] sum_o,
  output logic         co_o,
  output logic         ovf_o
);

  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{S{1'b0}}, c_i};
  // Only meaningful on the top slice, where b_i is the effective (possibly inverted) B.
  assign ovf_o = (a_i[S-1] == b_i[S-1]) && (sum_o[S-1] != a_i[S-1]);

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: carry chain cut into STAGES equal slices, one per register stage,
// with a single global stall enable for valid/ready backpressure.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_result,
  output logic             sum_carry,
  output logic             sum_ovf
);

  localparam int               S     = slice_w(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({S{1'b1}});

  if (WIDTH < 2) begin : g_bad_width
    $error("pipe_addsub: WIDTH must be >= 2");
  end
  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipe_addsub: STAGES must be in 1..WIDTH");
  end else if (WIDTH % STAGES != 0) begin : g_bad_div
    $error("pipe_addsub: WIDTH must be divisible by STAGES");
  end

  logic                         en, sub_en, ovf_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, r_in, r_nx;
  logic [STAGES-1:0]            vld_q, c_q, v_in, c_in, c_nx, s_ovf;
  logic [STAGES-1:0][S-1:0]     s_sum;

  assign sub_en   = (op_sub == OP_SUB);
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_in[0] = in_valid;
      assign a_in[0] = value_a;
      assign b_in[0] = value_b ^ {WIDTH{sub_en}};
      assign c_in[0] = sub_en;
      assign r_in[0] = '0;
    end else begin : g_body
      assign v_in[k] = vld_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign r_in[k] = r_q[k-1];
    end

    addsub_slice #(.S(S)) u_slice (
      .a_i  (a_in[k][k*S +: S]),
      .b_i  (b_in[k][k*S +: S]),
      .c_i  (c_in[k]),
      .sum_o(s_sum[k]),
      .co_o (c_nx[k]),
      .ovf_o(s_ovf[k])
    );

    // Drop this stage's slice into the partial result travelling with the token.
    assign r_nx[k] = (r_in[k] & ~(SMASK << (k*S))) | (WIDTH'(s_sum[k]) << (k*S));
  end

  // Whole pipeline advances together; bubbles carry stale data with valid low.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= v_in;
      a_q   <= a_in;
      b_q   <= b_in;
      r_q   <= r_nx;
      c_q   <= c_nx;
      ovf_q <= s_ovf[STAGES-1];
    end
  end

  assign out_valid  = vld_q[STAGES-1];
  assign sum_result = r_q[STAGES-1];
  assign sum_carry  = c_q[STAGES-1];
  assign sum_ovf    = ovf_q;

  // Operand slices already consumed and lower-slice overflow flags have no reader.
  logic unused_bits;
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], s_ovf, a_in, b_in};

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: 8/2 and 16/4 instances against an arithmetic reference model.
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       e_iv, e_ir, e_sub, e_ov, e_or, e_c, e_o;
  logic [7:0] e_a, e_b, e_r;
  logic        w_iv, w_ir, w_sub, w_ov, w_or, w_c, w_o;
  logic [15:0] w_a, w_b, w_r;

  pipe_addsub #(.WIDTH(8), .STAGES(2)) u_d8 (
    .clk(clk), .reset(rst), .in_valid(e_iv), .in_ready(e_ir), .value_a(e_a), .value_b(e_b),
    .op_sub(e_sub), .out_valid(e_ov), .out_ready(e_or), .sum_result(e_r), .sum_carry(e_c),
    .sum_ovf(e_o));

  pipe_addsub #(.WIDTH(16), .STAGES(4)) u_d16 (
    .clk(clk), .reset(rst), .in_valid(w_iv), .in_ready(w_ir), .value_a(w_a), .value_b(w_b),
    .op_sub(w_sub), .out_valid(w_ov), .out_ready(w_or), .sum_result(w_r), .sum_carry(w_c),
    .sum_ovf(w_o));

  int nvec = 0;
  int nbad = 0;
  logic [17:0] q8[$];
  logic [17:0] q16[$];

  // Reference: {ovf, carry, result} from plain integer arithmetic on unsigned and signed views.
  function automatic logic [17:0] ref_op(input int w, input int a, input int b, input bit sub);
    int mask, r, sa, sb, sr;
    bit c, o;
    mask = (1 << w) - 1;
    if (!sub) begin r = a + b; c = (r > mask); end
    else      begin r = a - b; c = (a >= b);   end
    sa = (a >= (1 << (w-1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w-1))) ? b - (1 << w) : b;
    sr = sub ? sa - sb : sa + sb;
    o  = (sr > (1 << (w-1)) - 1) || (sr < -(1 << (w-1)));
    return {o, c, 16'(r & mask)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nvec++; if (e_ir !== 1'b0 || w_ir !== 1'b0)
      begin nbad++; $display("FAIL reset_in_ready: got %b/%b want 0/0", e_ir, w_ir); end
    nvec++; if ({e_ov, e_r, e_c, e_o} !== 11'd0)
      begin nbad++; $display("FAIL reset_out8: got %h want 0", {e_ov, e_r, e_c, e_o}); end
    nvec++; if ({w_ov, w_r, w_c, w_o} !== 19'd0)
      begin nbad++; $display("FAIL reset_out16: got %h want 0", {w_ov, w_r, w_c, w_o}); end
    rst = 1'b0;
    #1;
    nvec++; if (e_ir !== 1'b1 || w_ir !== 1'b1)
      begin nbad++; $display("FAIL post_reset_ready: got %b/%b want 1/1", e_ir, w_ir); end
  endtask

  task automatic test_arith();
    logic [7:0] ta[6] = '{8'd15, 8'd255, 8'd127, 8'd0, 8'd170, 8'd128};
    logic [7:0] tb[6] = '{8'd1,  8'd1,   8'd1,   8'd1, 8'd85,  8'd1};
    bit         ts[6] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
    logic [17:0] exp;
    for (int i = 0; i < 6; i++) begin
      e_a = ta[i]; e_b = tb[i]; e_sub = ts[i]; e_iv = 1'b1; e_or = 1'b1;
      #1;
      nvec++; if (e_ir !== 1'b1)
        begin nbad++; $display("FAIL arith_in_ready[%0d]: got %b want 1", i, e_ir); end
      exp = ref_op(8, int'(ta[i]), int'(tb[i]), ts[i]);
      tick();
      e_iv = 1'b0;
      nvec++; if (e_ov !== 1'b0)
        begin nbad++; $display("FAIL arith_early[%0d]: out_valid %b want 0", i, e_ov); end
      tick();
      nvec++; if ({e_ov, e_r, e_c, e_o} !== {1'b1, exp[7:0], exp[16], exp[17]})
        begin nbad++; $display("FAIL arith_result[%0d]: got v%b r%0d c%b o%b want v1 r%0d c%b o%b",
          i, e_ov, e_r, e_c, e_o, exp[7:0], exp[16], exp[17]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba[4] = '{8'd0, 8'd255, 8'd170, 8'd1};
    logic [7:0] bb[4] = '{8'd0, 8'd255, 8'd85,  8'd2};
    logic [17:0] exp;
    int sent = 0, got = 0, held = 0;
    q8.delete();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      e_iv = (sent < 4);
      e_a = ba[sent % 4]; e_b = bb[sent % 4]; e_sub = OP_ADD;
      if (e_ov && held < 3) begin e_or = 1'b0; held++; end
      else e_or = 1'b1;
      #1;
      if (!e_or) begin
        nvec++; if (e_ir !== 1'b0)
          begin nbad++; $display("FAIL bp_in_ready: got %b want 0", e_ir); end
        exp = q8[0];
        nvec++; if ({e_r, e_c, e_o} !== {exp[7:0], exp[16], exp[17]})
          begin nbad++; $display("FAIL bp_stable: got r%0d c%b o%b want r%0d c%b o%b",
            e_r, e_c, e_o, exp[7:0], exp[16], exp[17]); end
      end else if (e_ov) begin
        exp = q8.pop_front();
        got++;
        nvec++; if ({e_r, e_c, e_o} !== {exp[7:0], exp[16], exp[17]})
          begin nbad++; $display("FAIL bp_result[%0d]: got r%0d c%b o%b want r%0d c%b o%b",
            got - 1, e_r, e_c, e_o, exp[7:0], exp[16], exp[17]); end
      end
      if (e_iv && e_ir) begin
        q8.push_back(ref_op(8, int'(ba[sent]), int'(bb[sent]), 1'b0));
        sent++;
      end
      tick();
    end
    e_iv = 1'b0;
    nvec++; if (got !== 4 || held !== 3 || q8.size() != 0)
      begin nbad++; $display("FAIL bp_count: got %0d held %0d left %0d want 4 3 0", got, held, q8.size()); end
    nvec++; if (e_ov !== 1'b0)
      begin nbad++; $display("FAIL bp_duplicate: out_valid %b want 0", e_ov); end
  endtask

  task automatic test_reset_midstream();
    logic [17:0] exp;
    e_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_iv = 1'b1; e_a = 8'($urandom); e_b = 8'($urandom); e_sub = 1'($urandom);
      tick();
    end
    e_iv = 1'b0;
    rst = 1'b1;
    #1;
    nvec++; if (e_ir !== 1'b0)
      begin nbad++; $display("FAIL mid_reset_ready: got %b want 0", e_ir); end
    tick();
    rst = 1'b0;
    nvec++; if ({e_ov, e_r, e_c, e_o} !== 11'd0)
      begin nbad++; $display("FAIL mid_reset_clear: got %h want 0", {e_ov, e_r, e_c, e_o}); end
    for (int i = 0; i < 4; i++) begin
      nvec++; if (e_ov !== 1'b0)
        begin nbad++; $display("FAIL mid_reset_stale[%0d]: out_valid %b want 0", i, e_ov); end
      tick();
    end
    e_iv = 1'b1; e_a = 8'd200; e_b = 8'd100; e_sub = OP_ADD;
    exp = ref_op(8, 200, 100, 1'b0);
    tick();
    e_iv = 1'b0;
    nvec++; if (e_ov !== 1'b0)
      begin nbad++; $display("FAIL mid_reset_early: out_valid %b want 0", e_ov); end
    tick();
    nvec++; if ({e_ov, e_r, e_c, e_o} !== {1'b1, exp[7:0], exp[16], exp[17]})
      begin nbad++; $display("FAIL mid_reset_result: got v%b r%0d c%b o%b want v1 r%0d c%b o%b",
        e_ov, e_r, e_c, e_o, exp[7:0], exp[16], exp[17]); end
    tick();
  endtask

  task automatic test_wide();
    w_iv = 1'b1; w_a = 16'hFFFF; w_b = 16'h0001; w_sub = OP_ADD; w_or = 1'b1;
    tick();
    w_iv = 1'b0;
    for (int k = 1; k < 4; k++) begin
      nvec++; if (w_ov !== 1'b0)
        begin nbad++; $display("FAIL wide_early[%0d]: out_valid %b want 0", k, w_ov); end
      tick();
    end
    nvec++; if ({w_ov, w_r, w_c, w_o} !== {1'b1, 16'h0000, 1'b1, 1'b0})
      begin nbad++; $display("FAIL wide_result: got v%b r%h c%b o%b want v1 r0000 c1 o0",
        w_ov, w_r, w_c, w_o); end
    tick();
  endtask

  task automatic test_random();
    logic [17:0] exp;
    int sent = 0, cyc = 0;
    q16.delete();
    while ((sent < 1000 || q16.size() != 0) && cyc < 20000) begin
      w_iv  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      w_a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      w_b   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      w_sub = 1'($urandom);
      w_or  = ($urandom_range(0, 3) != 0);
      #1;
      nvec++; if (w_ir !== (!w_ov || w_or))
        begin nbad++; $display("FAIL rand_in_ready: got %b with out_valid %b out_ready %b", w_ir, w_ov, w_or); end
      if (w_ov && w_or) begin
        nvec++;
        if (q16.size() == 0) begin
          nbad++; $display("FAIL rand_spurious: result %h with nothing outstanding", w_r);
        end else begin
          exp = q16.pop_front();
          if ({w_r, w_c, w_o} !== {exp[15:0], exp[16], exp[17]})
            begin nbad++; $display("FAIL rand_result: got r%h c%b o%b want r%h c%b o%b",
              w_r, w_c, w_o, exp[15:0], exp[16], exp[17]); end
        end
      end
      if (w_iv && w_ir) begin
        q16.push_back(ref_op(16, int'(w_a), int'(w_b), w_sub));
        sent++;
      end
      tick();
      cyc++;
    end
    w_iv = 1'b0;
    nvec++; if (sent != 1000 || q16.size() != 0)
      begin nbad++; $display("FAIL rand_timeout: sent %0d outstanding %0d want 1000 0", sent, q16.size()); end
  endtask

  initial begin
    e_iv = 1'b0; e_a = '0; e_b = '0; e_sub = 1'b0; e_or = 1'b1;
    w_iv = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_or = 1'b1;
    rst = 1'b1;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_midstream();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the team's 8-bit adder.
- Operand width and pipeline depth are configurable. The carry chain is split into equal slices, one slice per stage.
- Valid/ready handshake on input and output, with full backpressure.
- Reports carry/borrow and signed overflow alongside the result. Sits between operand producers and any result consumer in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits. WIDTH must be >= 2 and divisible by STAGES.
- STAGES, 2, number of register stages and carry-chain slices. 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present on value_a, value_b, op_sub.
- in_ready  out  1  block can accept operands this cycle.
- value_a  in  WIDTH  operand A.
- value_b  in  WIDTH  operand B.
- op_sub  in  1  0 = A+B; 1 = A-B.
- out_valid  out  1  result present on sum_result, sum_carry, sum_ovf.
- out_ready  in  1  consumer accepts the result this cycle.
- sum_result  out  WIDTH  result modulo 2^WIDTH.
- sum_carry  out  1  carry out of MSB. For subtract this is not-borrow: 1 when A >= B unsigned.
- sum_ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - Clears every stage valid bit, all data registers and all outputs to 0.
  - in_ready = 0 in any cycle where reset = 1.
  - Asserting reset mid-stream discards all in-flight operations; no result emerges for them.
  - in_ready = 1 in the first cycle after reset is released.
- Stall rule:
  - Global advance enable is en = !out_valid || out_ready.
  - in_ready = en and !reset.
  - When en = 0, every stage holds its contents and outputs are stable.
  - Bubbles are not collapsed.
- Accept: a transfer occurs when in_valid && in_ready; inputs are sampled in that cycle.
- Arithmetic:
  - Effective B is value_b XOR {WIDTH{op_sub}}; carry-in is op_sub.
  - Stage k (0..STAGES-1) adds bits [k*S +: S], where S = WIDTH/STAGES, using the carry registered from stage k-1.
  - Lower result slices and not-yet-used upper operand slices travel with the token.
  - sum_ovf = (a_msb == beff_msb) && (sum_msb != a_msb).
- Latency: exactly STAGES cycles from accept to out_valid when unstalled.
- Throughput: one operation per cycle when out_ready is held high.
- Output transfer: occurs when out_valid && out_ready. With the pipeline full and out_ready = 1, accept and emit happen in the same cycle and nothing is lost.
- Stable outputs: while out_valid = 1 and out_ready = 0, sum_result, sum_carry and sum_ovf must not change.
- No reordering and no dropping; results emerge in accept order.
- in_valid = 0 with en = 1 injects a bubble: stage valid = 0 and data registers may hold stale values.
- Outputs with out_valid = 0 are don't-care to the consumer but must be 0 after reset.
- Elaboration-time errors:
  - WIDTH % STAGES != 0.
  - STAGES outside the range 1..WIDTH.

Decomposition:
- Shared package pipe_addsub_pkg holds:
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - the slice-width helper function (WIDTH/STAGES).
- One sub-module, addsub_slice: a combinational S-bit adder with carry-in, carry-out and MSB-overflow output. It is instantiated STAGES times inside a generate loop. Pipeline registers stay in the top level.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1. Accept 15+1 -> out_valid exactly 2 cycles later with sum_result=16, sum_carry=0, sum_ovf=0.
- Accept 255+1 -> sum_result=0, sum_carry=1, sum_ovf=0. Accept 127+1 -> sum_result=128, sum_carry=0, sum_ovf=1.
- op_sub=1:
  - 0-1 -> sum_result=255, sum_carry=0, sum_ovf=0.
  - 170-85 -> sum_result=85, sum_carry=1.
  - 128-1 -> sum_result=127, sum_ovf=1.
- Backpressure:
  - Stream 4 back-to-back ops (0+0, 255+255, 170+85, 1+2) and hold out_ready=0 for 3 cycles once out_valid rises.
  - While held, in_ready=0 and outputs stay stable.
  - After release, results 0, 254 (carry 1), 255 and 3 emerge in order, with no loss or duplication.
- Reset mid-stream: accept 3 ops, assert reset for 1 cycle -> out_valid=0 and all outputs 0 next cycle. No stale result appears afterwards; the next accepted op returns correctly with latency 2.
- WIDTH=16, STAGES=4: 0xFFFF+0x0001 -> 0x0000 with carry 1, 4 cycles after accept. Random 1000 ops with random in_valid and out_ready versus a scoreboard -> all results match in order.
